exp3_fluxo_dados: RTL and testbench
===================================

Name: exp3_fluxo_dados

Overview:
- Datapath responder to the game's control unit.
- Receives zeraC/contaC/zeraR/registraR and returns fimC/igual.
- Holds:
  - address counter
  - switch register (chaves)
  - fixed 16x4 pattern ROM
  - equality comparator between registered switches and ROM data at the current address
- Exposes debug buses for the 7-segment/LED board wiring.

Parameters:
- N, 4, data width of chaves, register and ROM words.
- ULTIMO, 15, last address; fimC asserts here; counter wraps to 0 after it.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clock rising edge)
- zeraC  input  1  clear address counter
- contaC  input  1  increment address counter
- zeraR  input  1  clear switch register
- registraR  input  1  load chaves into switch register
- chaves  input  N  player switch inputs
- fimC  output  1  counter at ULTIMO
- igual  output  1  switch register equals ROM word at current address
- db_contagem  output  4  current address
- db_memoria  output  N  ROM word at current address
- db_chaves  output  N  switch register contents

Behaviour:
- All state registers update only on clock rising edge. No asynchronous paths into state.
- Reset:
  - reset==0 at an edge sets counter=0 and register=0, regardless of every other input.
  - Afterwards: db_contagem=0, db_chaves=0000, db_memoria=0001, fimC=0, igual=0.
- Counter priority per edge: reset > zeraC > contaC > hold.
  - zeraC and contaC both 1: counter becomes 0.
  - contaC at ULTIMO: counter wraps to 0.
  - contaC elsewhere: counter+1, visible the following cycle.
- Register priority per edge: reset > zeraR > registraR > hold.
  - zeraR and registraR both 1: register becomes 0.
  - registraR loads chaves as sampled at that edge. Later chaves changes are ignored until the next load.
- Counter and register are independent. Any combination of the four controls in one cycle is legal.
- ROM: combinational read, 16 entries, address = counter. Contents, addr 0..15:
  - 0001, 0010, 0100, 1000
  - 0100, 0010, 0001, 0001
  - 0010, 0010, 0100, 0100
  - 1000, 1000, 0001, 0100
- fimC = (counter == ULTIMO). Combinational from state.
- igual = (register == ROM[counter]). Combinational from state. Does not depend on live chaves.
- Latency:
  - registraR at edge k gives a valid igual during cycle k+1. This lines up with the controller's comparison state directly after its register state.
  - contaC at edge k gives fimC/igual for the new address during cycle k+1.
- Debug outputs mirror state combinationally: db_contagem=counter, db_chaves=register, db_memoria=ROM[counter].
- Reset mid-operation: any cycle with reset==0 restores the reset values on the next edge. In-flight count/load is discarded.
- Counter is 4 bits regardless of ULTIMO. For ULTIMO<15, addresses above ULTIMO are unreachable except after direct reset misuse. They still read the ROM table above.

Test Plan:
- Reset: hold reset=0 two cycles with contaC=1, registraR=1, chaves=1111 -> db_contagem=0, db_chaves=0000, fimC=0, igual=0.
- Match at addr 0: reset=1, chaves=0001, pulse registraR one cycle -> next cycle db_chaves=0001, db_memoria=0001, igual=1. Change chaves to 1000 -> igual stays 1.
- Mismatch then advance: register=0001, pulse contaC -> db_contagem=1, db_memoria=0010, igual=0. Load 0010 -> igual=1.
- Full sweep: from 0, pulse contaC 15 times -> db_contagem=15, db_memoria=0100, fimC=1. One more contaC -> db_contagem=0, fimC=0.
- Priority: at addr 5 with register=0010, assert zeraC=contaC=1 and zeraR=registraR=1 with chaves=1111 -> db_contagem=0, db_chaves=0000, igual=0.
- Reset mid-sweep: at addr 9 with register=0010, drive reset=0 one cycle with contaC=1 -> db_contagem=0, db_chaves=0000. Normal counting resumes after reset=1.

Source files
------------

// File: rtl/exp3_fluxo_dados_if.sv
// Control/status bundle between the game's control unit (master) and the
// datapath (slave), including the debug buses wired to the board displays.
interface exp3_fluxo_dados_if #(
  parameter int N = 4
);
  logic         zeraC;
  logic         contaC;
  logic         zeraR;
  logic         registraR;
  logic [N-1:0] chaves;
  logic         fimC;
  logic         igual;
  logic [3:0]   db_contagem;
  logic [N-1:0] db_memoria;
  logic [N-1:0] db_chaves;

  modport master (
    output zeraC, contaC, zeraR, registraR, chaves,
    input  fimC, igual, db_contagem, db_memoria, db_chaves
  );

  modport slave (
    input  zeraC, contaC, zeraR, registraR, chaves,
    output fimC, igual, db_contagem, db_memoria, db_chaves
  );
endinterface

// File: rtl/exp3_fluxo_dados.sv
// Game datapath: address counter, switch register, fixed 16x4 pattern ROM
// and an equality comparator between the stored switches and the ROM word.
module exp3_fluxo_dados #(
  parameter int N      = 4,
  parameter int ULTIMO = 15
) (
  input  logic               clock,
  input  logic               reset,
  exp3_fluxo_dados_if.slave  bus
);

  localparam logic [3:0] ULTIMO_ADDR = 4'(ULTIMO);

  localparam logic [3:0] ROM_TABLE [16] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0100, 4'b0010, 4'b0001, 4'b0001,
    4'b0010, 4'b0010, 4'b0100, 4'b0100,
    4'b1000, 4'b1000, 4'b0001, 4'b0100
  };

  logic [3:0]   cont_q, cont_d;
  logic [N-1:0] reg_q, reg_d;
  logic [N-1:0] rom_data;
  logic [N-1:0] bit_eq;

  // Clear wins over count/load when both are requested in the same cycle.
  always_comb begin
    cont_d = cont_q;
    if (bus.zeraC) begin
      cont_d = '0;
    end else if (bus.contaC) begin
      cont_d = (cont_q == ULTIMO_ADDR) ? 4'd0 : cont_q + 4'd1;
    end
  end

  always_comb begin
    reg_d = reg_q;
    if (bus.zeraR) begin
      reg_d = '0;
    end else if (bus.registraR) begin
      reg_d = bus.chaves;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cont_q <= '0;
      reg_q  <= '0;
    end else begin
      cont_q <= cont_d;
      reg_q  <= reg_d;
    end
  end

  assign rom_data = N'(ROM_TABLE[cont_q]);

  // Compare against the stored register, never the live switches.
  for (genvar gi = 0; gi < N; gi++) begin : g_cmp
    assign bit_eq[gi] = ~(reg_q[gi] ^ rom_data[gi]);
  end

  assign bus.igual       = &bit_eq;
  assign bus.fimC        = (cont_q == ULTIMO_ADDR);
  assign bus.db_contagem = cont_q;
  assign bus.db_memoria  = rom_data;
  assign bus.db_chaves   = reg_q;

endmodule

// File: tb/tb_exp3_fluxo_dados.sv
// Self-checking bench: directed vector table, sweep/wrap sequence and random
// control stimulus compared against a behavioural model of the datapath.
module tb_exp3_fluxo_dados;

  logic clock;
  logic reset;

  exp3_fluxo_dados_if #(.N(4)) bus ();

  exp3_fluxo_dados #(.N(4), .ULTIMO(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       zc;
    logic       cc;
    logic       zr;
    logic       rr;
    logic [3:0] ch;
    int         ecnt;
    int         ereg;
    logic       efim;
    logic       eig;
  } vec_t;

  vec_t tbl[$];

  logic [3:0] rom_ref [16] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
    4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
  };

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt = 0;
  int m_reg = 0;

  function automatic vec_t mk(logic rst, logic zc, logic cc, logic zr, logic rr,
                              logic [3:0] ch, int ecnt, int ereg, logic efim, logic eig);
    vec_t v;
    v.rst = rst; v.zc = zc; v.cc = cc; v.zr = zr; v.rr = rr; v.ch = ch;
    v.ecnt = ecnt; v.ereg = ereg; v.efim = efim; v.eig = eig;
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Drive one cycle of controls, clock it, advance the model, settle past the edge.
  task automatic drive(input logic r, input logic zc, input logic cc,
                       input logic zr, input logic rr, input logic [3:0] ch);
    reset         = r;
    bus.zeraC     = zc;
    bus.contaC    = cc;
    bus.zeraR     = zr;
    bus.registraR = rr;
    bus.chaves    = ch;
    @(posedge clock);
    if (!r) begin
      m_cnt = 0;
      m_reg = 0;
    end else begin
      if (zc)      m_cnt = 0;
      else if (cc) m_cnt = (m_cnt + 1) % 16;
      if (zr)      m_reg = 0;
      else if (rr) m_reg = int'(ch);
    end
    #1;
  endtask

  task automatic check_all(input string tag, input int ecnt, input int ereg,
                           input logic efim, input logic eig);
    $display("%s: rst=%0b zc=%0b cc=%0b zr=%0b rr=%0b ch=%h -> cnt=%0d reg=%h mem=%h fim=%0b ig=%0b",
             tag, reset, bus.zeraC, bus.contaC, bus.zeraR, bus.registraR, bus.chaves,
             bus.db_contagem, bus.db_chaves, bus.db_memoria, bus.fimC, bus.igual);
    cmp({tag, ".db_contagem"}, int'(bus.db_contagem), ecnt);
    cmp({tag, ".db_chaves"},   int'(bus.db_chaves),   ereg);
    cmp({tag, ".db_memoria"},  int'(bus.db_memoria),  int'(rom_ref[ecnt[3:0]]));
    cmp({tag, ".fimC"},        int'(bus.fimC),        int'(efim));
    cmp({tag, ".igual"},       int'(bus.igual),       int'(eig));
  endtask

  initial begin
    vec_t v;
    reset = 1'b0;
    bus.zeraC = 1'b0; bus.contaC = 1'b0; bus.zeraR = 1'b0; bus.registraR = 1'b0;
    bus.chaves = 4'h0;

    // Expected values are the state visible in the cycle after each edge.
    tbl.push_back(mk(0, 0, 1, 0, 1, 4'hF, 0, 0, 0, 0));  // reset dominates
    tbl.push_back(mk(0, 0, 1, 0, 1, 4'hF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 4'h1, 0, 1, 0, 1));  // match at addr 0
    tbl.push_back(mk(1, 0, 0, 0, 0, 4'h8, 0, 1, 0, 1));  // live chaves ignored
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h8, 1, 1, 0, 0));  // advance -> mismatch
    tbl.push_back(mk(1, 0, 0, 0, 1, 4'h2, 1, 2, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 2, 2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 3, 2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 4, 2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 5, 2, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 4'hF, 0, 0, 0, 0));  // clears win
    tbl.push_back(mk(1, 0, 1, 0, 1, 4'h2, 1, 2, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 2, 2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 3, 2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 4, 2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 5, 2, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 6, 2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 7, 2, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 8, 2, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 9, 2, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4'h0, 0, 0, 0, 0));  // reset mid-sweep
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 4'h0, 2, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.rst, v.zc, v.cc, v.zr, v.rr, v.ch);
      check_all($sformatf("vec%0d", i), v.ecnt, v.ereg, v.efim, v.eig);
    end

    // Full sweep from 0: fimC only at 15, then wrap back to 0.
    drive(0, 0, 0, 0, 0, 4'h0);
    check_all("sweep_rst", 0, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      drive(1, 0, 1, 0, 0, 4'h0);
      check_all($sformatf("sweep%0d", i), i, 0, (i == 15), 1'b0);
    end
    drive(1, 0, 1, 0, 0, 4'h0);
    check_all("sweep_wrap", 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [3:0] ch;
      r  = ($urandom_range(0, 15) != 0);
      ch = 4'($urandom_range(0, 15));
      drive(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), ch);
      check_all($sformatf("rnd%0d", i), m_cnt, m_reg, (m_cnt == 15),
                (m_reg == int'(rom_ref[m_cnt])));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
